// File: rtl/regfile_write_scheduler.sv
// Round-robin scheduler sharing four register-file write ports among NUM_REQ requesters.
// Grants at most one write per address per cycle; granted writes are registered once.
module regfile_write_scheduler #(
  parameter  int NUM_REQ   = 6,
  parameter  int NUM_PORTS = 4,
  parameter  int ADDR_W    = 3,
  parameter  int DATA_W    = 64,
  parameter  int MASK_W    = DATA_W / 8,
  localparam int PTR_W     = $clog2(NUM_REQ),
  localparam int NUM_ADDR  = 2 ** ADDR_W
) (
  input  logic                          R0_clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ*MASK_W-1:0]     req_mask,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]          w_en,
  output logic [NUM_PORTS*ADDR_W-1:0]   w_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   w_data,
  output logic [NUM_PORTS*MASK_W-1:0]   w_mask,
  output logic [NUM_ADDR-1:0]           pending,
  output logic [PTR_W-1:0]              rr_ptr_o
);

  localparam int CNT_W  = $clog2(NUM_PORTS + 1);
  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic [PTR_W-1:0]     port_src [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_grant;

  logic [NUM_PORTS-1:0] w_en_reg;
  logic [ADDR_W-1:0]    w_addr_reg [NUM_PORTS];
  logic [DATA_W-1:0]    w_data_reg [NUM_PORTS];
  logic [MASK_W-1:0]    w_mask_reg [NUM_PORTS];

  // Scan from rr_ptr; the k-th grant in scan order is steered to port k.
  always_comb begin : grant_scan
    logic [NUM_ADDR-1:0] addr_used;
    logic [CNT_W-1:0]    grant_cnt;
    logic [PTR_W-1:0]    scan_idx;
    logic [PTR_W-1:0]    last_idx;
    logic [ADDR_W-1:0]   scan_addr;
    req_ready  = '0;
    port_grant = '0;
    addr_used  = '0;
    grant_cnt  = '0;
    last_idx   = rr_ptr_reg;
    scan_idx   = '0;
    scan_addr  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      port_src[k] = '0;
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      scan_idx  = PTR_W'((int'(rr_ptr_reg) + j) % NUM_REQ);
      scan_addr = req_addr[scan_idx*ADDR_W +: ADDR_W];
      if (!stall && req_valid[scan_idx] && (grant_cnt < CNT_W'(NUM_PORTS)) &&
          !addr_used[scan_addr]) begin
        req_ready[scan_idx]                  = 1'b1;
        addr_used[scan_addr]                 = 1'b1;
        port_src[grant_cnt[PORT_W-1:0]]      = scan_idx;
        port_grant[grant_cnt[PORT_W-1:0]]    = 1'b1;
        grant_cnt                            = grant_cnt + 1'b1;
        last_idx                             = scan_idx;
      end
    end
    rr_ptr_next = rr_ptr_reg;
    if (grant_cnt != '0) begin
      rr_ptr_next = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  // Disabled ports keep their last payload; only the enable is cleared.
  always_ff @(posedge R0_clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      w_en_reg   <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_addr_reg[k] <= '0;
        w_data_reg[k] <= '0;
        w_mask_reg[k] <= '0;
      end
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      w_en_reg   <= port_grant;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (port_grant[k]) begin
          w_addr_reg[k] <= req_addr[port_src[k]*ADDR_W +: ADDR_W];
          w_data_reg[k] <= req_data[port_src[k]*DATA_W +: DATA_W];
          w_mask_reg[k] <= req_mask[port_src[k]*MASK_W +: MASK_W];
        end
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_en_reg[k]) begin
        pending[w_addr_reg[k]] = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_out
      assign w_addr[gi*ADDR_W +: ADDR_W] = w_addr_reg[gi];
      assign w_data[gi*DATA_W +: DATA_W] = w_data_reg[gi];
      assign w_mask[gi*MASK_W +: MASK_W] = w_mask_reg[gi];
    end
  endgenerate

  assign w_en     = w_en_reg;
  assign rr_ptr_o = rr_ptr_reg;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios with literal expectations,
// a per-cycle comparison against a behavioural scheduler model, and a random run.
module tb_regfile_write_scheduler;

  localparam int NR = 6;
  localparam int NP = 4;
  localparam int AW = 3;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int PW = $clog2(NR);
  localparam int NA = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*MW-1:0] req_mask = '0;
  logic [NR-1:0]   req_ready;
  logic [NP-1:0]   w_en;
  logic [NP*AW-1:0] w_addr;
  logic [NP*DW-1:0] w_data;
  logic [NP*MW-1:0] w_mask;
  logic [NA-1:0]   pending;
  logic [PW-1:0]   rr_ptr_o;

  regfile_write_scheduler dut (
    .R0_clk   (clk),
    .reset    (reset),
    .stall    (stall),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_mask (req_mask),
    .req_ready(req_ready),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_mask   (w_mask),
    .pending  (pending),
    .rr_ptr_o (rr_ptr_o)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Behavioural model: expected registered write stage, pointer and memory image.
  int              m_rr;
  logic [NP-1:0]   m_wen;
  logic [AW-1:0]   m_addr [NP];
  logic [DW-1:0]   m_data [NP];
  logic [MW-1:0]   m_mask [NP];
  logic [DW-1:0]   model_mem [NA];
  logic [DW-1:0]   dut_mem [NA];
  int              wait_cnt [NR];

  // Grant rule: walk requesters from rr in a circle, take valid ones whose address
  // is not yet taken, until four have been taken.
  function automatic void model_scan(input int rr, output logic [NR-1:0] g,
                                     output int ord[NP], output int n);
    int seq[$];
    int taken[$];
    g = '0;
    n = 0;
    for (int k = 0; k < NP; k++) ord[k] = 0;
    for (int j = 0; j < NR; j++) seq.push_back((rr + j) % NR);
    foreach (seq[j]) begin
      int  id;
      int  a;
      bit  clash;
      id = seq[j];
      a  = int'(req_addr[id*AW +: AW]);
      clash = 1'b0;
      foreach (taken[t]) if (taken[t] == a) clash = 1'b1;
      if (!stall && req_valid[id] && n < NP && !clash) begin
        g[id] = 1'b1;
        ord[n] = id;
        taken.push_back(a);
        n++;
      end
    end
  endfunction

  always @(posedge clk or posedge reset) begin : model_step
    logic [NR-1:0] g;
    int ord[NP];
    int n;
    int id;
    if (reset) begin
      m_rr  <= 0;
      m_wen <= '0;
      for (int k = 0; k < NP; k++) begin
        m_addr[k] <= '0;
        m_data[k] <= '0;
        m_mask[k] <= '0;
      end
    end else begin
      model_scan(m_rr, g, ord, n);
      for (int k = 0; k < NP; k++) begin
        m_wen[k] <= (k < n);
        if (k < n) begin
          id = ord[k];
          m_addr[k] <= req_addr[id*AW +: AW];
          m_data[k] <= req_data[id*DW +: DW];
          m_mask[k] <= req_mask[id*MW +: MW];
          for (int b = 0; b < MW; b++)
            if (req_mask[id*MW + b])
              model_mem[req_addr[id*AW +: AW]][b*8 +: 8] <= req_data[id*DW + b*8 +: 8];
        end
      end
      if (n > 0) m_rr <= (ord[n-1] + 1) % NR;
    end
  end

  // Register file image as written by the DUT's ports.
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NP; k++)
        if (w_en[k])
          for (int b = 0; b < MW; b++)
            if (w_mask[k*MW + b])
              dut_mem[w_addr[k*AW +: AW]][b*8 +: 8] <= w_data[k*DW + b*8 +: 8];
    end
  end

  always @(negedge clk) begin : compare
    logic [NR-1:0] g;
    int ord[NP];
    int n;
    logic [NA-1:0] exp_pend;
    logic [NA-1:0] used;
    bit clash;
    int worst;
    if (chk_en && !reset) begin
      model_scan(m_rr, g, ord, n);
      check("req_ready", 64'(req_ready), 64'(g));
      check("rr_ptr", 64'(rr_ptr_o), 64'(m_rr));
      check("w_en", 64'(w_en), 64'(m_wen));
      exp_pend = '0;
      for (int k = 0; k < NP; k++) begin
        if (m_wen[k]) begin
          exp_pend[m_addr[k]] = 1'b1;
          check($sformatf("w_addr%0d", k), 64'(w_addr[k*AW +: AW]), 64'(m_addr[k]));
          check($sformatf("w_data%0d", k), w_data[k*DW +: DW], m_data[k]);
          check($sformatf("w_mask%0d", k), 64'(w_mask[k*MW +: MW]), 64'(m_mask[k]));
        end
      end
      check("pending", 64'(pending), 64'(exp_pend));
      used = '0;
      clash = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin
          if (used[req_addr[i*AW +: AW]]) clash = 1'b1;
          used[req_addr[i*AW +: AW]] = 1'b1;
        end
      end
      check("addr_unique", 64'(clash), 64'd0);
      check("ready_wo_valid", 64'(req_ready & ~req_valid), 64'd0);
      worst = 0;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          if (!stall) wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      check("starve_wait", 64'(worst > NR), 64'd0);
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_mask[i*MW +: MW] = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    stall     = 1'b0;
    @(negedge clk);
    check("rst_w_en", 64'(w_en), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_rr_ptr", 64'(rr_ptr_o), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_w_mask", 64'(w_mask), 64'd0);
    check("rst_w_data0", w_data[DW-1:0], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    step();
  endtask

  logic [NR-1:0] acc;

  initial begin
    for (int a = 0; a < NA; a++) begin
      model_mem[a] = '0;
      dut_mem[a]   = '0;
    end
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    chk_en = 1'b1;

    // Four requesters, distinct addresses: all granted, written next cycle.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, AW'(i + 1), 64'h1000 + 64'(i), 8'hFF);
    req_valid = 6'b001111;
    @(negedge clk);
    check("t1_ready", 64'(req_ready), 64'b001111);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_w_en", 64'(w_en), 64'hF);
    check("t1_w_addr", 64'(w_addr), 64'h8D1);
    check("t1_pending", 64'(pending), 64'b00011110);
    check("t1_rr_ptr", 64'(rr_ptr_o), 64'd4);
    $display("t1: w_en=%b w_addr=%h pending=%b rr=%0d", w_en, w_addr, pending, rr_ptr_o);

    // Six requesters: the cap of four defers 4 and 5 to the next cycle.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i), 64'h2000 + 64'(i), 8'hFF);
    req_valid = 6'b111111;
    @(negedge clk);
    check("t2_ready0", 64'(req_ready), 64'b001111);
    step();
    req_valid = 6'b110000;
    @(negedge clk);
    check("t2_ready1", 64'(req_ready), 64'b110000);
    check("t2_rr1", 64'(rr_ptr_o), 64'd4);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t2_rr2", 64'(rr_ptr_o), 64'd0);
    check("t2_w_en", 64'(w_en), 64'b0011);
    $display("t2: w_en=%b rr=%0d", w_en, rr_ptr_o);

    // Same-address conflict: requester 2 waits one cycle behind requester 1.
    do_reset();
    set_req(1, 3'd5, 64'hAAAA, 8'hFF);
    set_req(2, 3'd5, 64'hBBBB, 8'hFF);
    req_valid = 6'b000110;
    @(negedge clk);
    check("t3_ready0", 64'(req_ready), 64'b000010);
    step();
    req_valid = 6'b000100;
    @(negedge clk);
    check("t3_ready1", 64'(req_ready), 64'b000100);
    check("t3_w_en1", 64'(w_en), 64'b0001);
    check("t3_addr1", 64'(w_addr[AW-1:0]), 64'd5);
    check("t3_data1", w_data[DW-1:0], 64'hAAAA);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t3_w_en2", 64'(w_en), 64'b0001);
    check("t3_addr2", 64'(w_addr[AW-1:0]), 64'd5);
    check("t3_data2", w_data[DW-1:0], 64'hBBBB);
    check("t3_rr", 64'(rr_ptr_o), 64'd3);
    $display("t3: w_addr0=%0d w_data0=%h rr=%0d", w_addr[AW-1:0], w_data[DW-1:0], rr_ptr_o);

    // Stall holds everything for three cycles, then all four go at once.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, AW'(i), 64'h3000 + 64'(i), 8'hF0);
    req_valid = 6'b001111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_stall_ready", 64'(req_ready), 64'd0);
      check("t4_stall_w_en", 64'(w_en), 64'd0);
      check("t4_stall_rr", 64'(rr_ptr_o), 64'd0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    check("t4_release_ready", 64'(req_ready), 64'b001111);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t4_w_en", 64'(w_en), 64'hF);
    $display("t4: w_en=%b after stall release", w_en);

    // Reset while a write to address 7 sits in the register stage.
    do_reset();
    set_req(0, 3'd7, 64'hDEAD_BEEF, 8'h0F);
    req_valid = 6'b000001;
    @(negedge clk);
    check("t5_ready", 64'(req_ready), 64'b000001);
    step();
    req_valid = '0;
    check("t5_w_en_before", 64'(w_en), 64'b0001);
    #2 reset = 1'b1;
    #1;
    check("t5_w_en_async", 64'(w_en), 64'd0);
    check("t5_pending_async", 64'(pending), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_no_write", 64'(w_en), 64'd0);
    end
    $display("t5: in-flight write discarded, w_en=%b", w_en);
    step();

    // Random run against the memory image model.
    for (int a = 0; a < NA; a++) begin
      model_mem[a] = '0;
      dut_mem[a]   = '0;
    end
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      stall = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 9) < 6) begin
          set_req(i, AW'($urandom_range(0, NA - 1)), {$urandom, $urandom},
                  ($urandom_range(0, 15) == 0) ? 8'h00 : MW'($urandom));
          req_valid[i] = 1'b1;
        end
      end
    end
    req_valid = '0;
    stall     = 1'b0;
    repeat (4) step();
    for (int a = 0; a < NA; a++)
      check($sformatf("mem%0d", a), dut_mem[a], model_mem[a]);
    $display("random: mem7=%h", dut_mem[7]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the four write ports (W0..W3) of the 8-entry x 64-bit byte-masked register file among NUM_REQ independent write requesters.
- Each cycle, a round-robin scan grants up to four requests. No two grants in the same cycle may target the same address.
- Granted writes drive the register file write ports through one register stage.
- A per-address pending vector lets read-side logic detect writes that are in flight.

Parameters:
- NUM_REQ, 6, number of write requesters (legal range 2..8).
- NUM_PORTS, 4, register file write ports; fixed at 4.
- ADDR_W, 3, register address width.
- DATA_W, 64, write data width.
- MASK_W, 8, byte-enable width (DATA_W/8).

Ports:
- clock  in  1  single clock; all write ports run from it.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  when high, blocks all grants this cycle.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_addr  in  NUM_REQ*ADDR_W  target address; requester i uses slice i.
- req_data  in  NUM_REQ*DATA_W  write data.
- req_mask  in  NUM_REQ*MASK_W  byte enables.
- req_ready  out  NUM_REQ  grant; the request is accepted when valid&ready.
- w_en  out  NUM_PORTS  per-port write enable to the register file (Wk_en).
- w_addr  out  NUM_PORTS*ADDR_W  per-port address.
- w_data  out  NUM_PORTS*DATA_W  per-port data.
- w_mask  out  NUM_PORTS*MASK_W  per-port byte mask.
- pending  out  2**ADDR_W  bit a is set when any w_en[k] is high with w_addr[k]==a.
- rr_ptr_o  out  clog2(NUM_REQ)  current round-robin start index (debug/verification).

Behaviour:
- Reset is asynchronous and active-high. During reset: w_en=0, w_addr=0, w_data=0, w_mask=0, rr_ptr=0, pending=0.
- req_ready is combinational from req_valid, req_addr, stall and rr_ptr.
- Requesters must hold valid and payload stable until ready. Ready is never asserted without valid.
- Grant scan:
  - Visit requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ, once each.
  - Grant a valid requester if fewer than 4 grants have been made so far and its address differs from every address already granted this cycle.
  - A skipped valid requester sees req_ready=0 and retries next cycle.
- stall=1 forces zero grants, so all req_ready=0.
- Port assignment: the k-th grant in scan order goes to port k (k=0..3). Unused ports get w_en=0.
- Latency: a request accepted in cycle N appears on w_* at cycle N+1 (registered), for exactly one cycle.
- Non-enabled ports: w_addr/w_data/w_mask hold their previous values; only w_en is cleared.
- Because addresses are distinct within a cycle, port order never affects the result. The register file's same-address priority (W3 over W0) is never exercised.
- A mask of 0 is legal: it consumes a port and an address slot, and writes nothing.
- Round-robin update:
  - If at least one grant is made, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - If no grant is made, rr_ptr is unchanged.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles when stall=0.
- pending is combinational from the w_* registers. It is 0 in any cycle where all w_en=0.
- Reset mid-operation: accepted writes still in the register stage are discarded (w_en cleared). No partial writes are issued afterwards.
- Back-to-back cycles may grant the same address again; successive register-file writes resolve in order.

Test Plan:
- Reset, then requesters 0..3 valid with addresses 1,2,3,4, masks 0xFF, stall=0:
  - Cycle 0: req_ready=0b001111.
  - Cycle 1: w_en=0b1111, w_addr={4,3,2,1} (port3..0), pending=0b00011110.
  - rr_ptr becomes 4.
- All 6 requesters valid, distinct addresses, held valid, rr_ptr=0:
  - Cycle 0: grants 0-3; rr_ptr becomes 4.
  - Cycle 1: grants 4,5 (requesters 0-3 deasserted after acceptance); rr_ptr becomes 0.
- Requesters 1 and 2 both valid with addr 5, rr_ptr=0:
  - Only requester 1 is ready; requester 2 is granted next cycle.
  - w_addr port0=5 on both consecutive cycles.
- stall=1 for 3 cycles with 4 valid requests:
  - req_ready=0, w_en=0 and rr_ptr unchanged throughout.
  - On stall release, all 4 are granted in one cycle.
- Assert reset in the cycle after a grant of addr 7, mask 0x0F:
  - w_en drops to 0 immediately (asynchronous); pending=0.
  - No write to addr 7 is observed.
- Constrained-random run, 10k cycles, against a reference model of the 8x64 register file:
  - Final memory contents match.
  - No same-address multi-grant occurs in any cycle.
  - No requester waits more than NUM_REQ cycles with stall=0.
